cam_pixel_packer: RTL
=====================

// Module: cam_pixel_packer
// PURPOSE
//  Generalised OV7670 capture front end: samples the DVP bus (vsync/href/p_data) on PixelClk and packs bytes into
//  RGB565 pixels. Writes a frame-start marker and the pixel words into the 17-bit camera FIFO (FIFO_cam write side).
//  Adds a 1-byte grayscale mode, a crop window, 2:1 decimation, FIFO back-pressure handling and status counters.
//  Sits between the camera pins and the PSRAM VideoController load queue; gated by memory calibration done.
// PARAMETERS
//  PIX_W    16   packed pixel width; FIFO word = {marker, pixel} = PIX_W+1 bits
//  CNT_W    10   width of column/row counters and crop fields (max 1023)
//  CNT_DROP 16   width of dropped-pixel counter
// PORTS
//  PixelClk     in   1         capture clock; p_data/href/cam_vsync sampled on rising edge
//  nRST         in   1         asynchronous, active-low reset
//  enable       in   1         capture allowed (init_done_0 && init_done_1)
//  cam_vsync    in   1         camera VSYNC, high = vertical blank
//  href         in   1         camera HREF, high = valid byte on p_data
//  p_data       in   8         camera byte
//  gray_mode    in   1         0: 2 bytes/pixel RGB565 (hi byte first); 1: 1 byte/pixel Y
//  decim        in   1         1: keep even columns of even rows only
//  crop_x0/crop_y0  in  CNT_W  crop window origin (pixels / lines)
//  crop_w/crop_h    in  CNT_W  crop window size; 0 = window empty
//  fifo_full    in   1         camera FIFO full
//  fifo_data    out  PIX_W+1   {1'b1,0} = frame start marker; {1'b0,pixel} = pixel
//  fifo_wr_en   out  1         one-cycle write strobe
//  frame_done   out  1         one-cycle pulse at end of each captured frame
//  overflow     out  1         sticky: a word was dropped because fifo_full
//  drop_cnt     out  CNT_DROP  saturating count of dropped words
//  frame_cnt    out  16        captured frames, wraps
// BEHAVIOUR
//  Reset: state=WAIT_ENABLE; fifo_data=0, fifo_wr_en=0, frame_done=0, overflow=0, drop_cnt=0, frame_cnt=0.
//  FSM: WAIT_ENABLE -(enable)-> WAIT_BLANK -(cam_vsync=1)-> WAIT_START -(cam_vsync=0)-> CAPTURE
//   -(cam_vsync=1)-> WAIT_START with frame_done=1 and frame_cnt+1 for one cycle. enable=0 in any state ->
//   WAIT_ENABLE next cycle, no further writes, partial pixel discarded. WAIT_BLANK ensures the first frame is whole.
//  On entry to CAPTURE: latch gray_mode, decim, crop_* for the whole frame. Clear col/row/byte-phase.
//   Queue marker 17'h10000; marker_pending holds until the first cycle with fifo_full=0 and is then written.
//  Byte phase toggles on each href=1 cycle. RGB565: byte0 -> pix[15:8], byte1 -> pix[7:0]. Gray: Y ->
//   {Y[7:3],Y[7:2],Y[7:3]}. Pixel complete on byte1 (or every byte in gray). Word written the following cycle
//   (latency 1 from the completing byte).
//  col increments per completed pixel; on href falling edge (href 1->0): col=0, byte phase=0, row+1.
//   Odd trailing byte in RGB565 mode is discarded at href fall. Counters saturate at 2^CNT_W-1.
//  Emit iff crop_x0<=col<crop_x0+crop_w AND crop_y0<=row<crop_y0+crop_h (CNT_W+1-bit sums, no wrap),
//   AND (decim=0 OR (col[0]=0 AND row[0]=0)).
//  Emit while fifo_full=1 or marker_pending=1: word dropped, overflow<=1, drop_cnt+1 (saturate). Never
//   write while full. overflow/drop_cnt clear only on reset. Marker is never dropped, only deferred.
//  cam_vsync=1 during CAPTURE takes priority over a same-cycle byte: byte ignored, pending pixel not written.
//  fifo_wr_en is high at most one cycle per completed pixel; fifo_data holds last value when wr_en=0.
// TESTING
//  1 Reset, enable=0, toggle vsync/href -> fifo_wr_en never 1, frame_cnt=0.
//  2 enable=1, start mid-frame (vsync=0), then 2 frames 4x2 RGB565 bytes 0x12,0x34.. -> first partial
//    frame ignored; each frame: 10000 then 8 words 0x1234..; frame_done pulses twice, frame_cnt=2.
//  3 gray_mode=1, byte 0xFF then 0x80 -> words 0x0FFFF, 0x08410, each 1 cycle after its byte.
//  4 8x4 frame, crop x0=2 w=3 y0=1 h=2, decim=0 -> 6 pixels (cols 2..4, rows 1..2); decim=1 -> crop 0/8/0/4
//    yields 8 pixels (even col, rows 0,2).
//  5 fifo_full=1 at vsync fall for 3 pixels -> marker written after full drops, 3 drops, overflow=1,
//    drop_cnt=3; no wr_en while full.
//  6 nRST low mid-line, and vsync rise on byte0 of a pixel -> outputs reset values; no half pixel written.

Source files
------------

// File: rtl/cam_pixel_packer.sv
// OV7670 DVP capture front end: packs camera bytes into RGB565 (or expanded Y) words
// and writes a frame-start marker plus pixels into the camera FIFO, with crop/decimation.
module cam_pixel_packer #(
  parameter int unsigned PIX_W    = 16,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned CNT_DROP = 16
) (
  input  logic                PixelClk,
  input  logic                nRST,
  input  logic                enable,
  input  logic                cam_vsync,
  input  logic                href,
  input  logic [7:0]          p_data,
  input  logic                gray_mode,
  input  logic                decim,
  input  logic [CNT_W-1:0]    crop_x0,
  input  logic [CNT_W-1:0]    crop_y0,
  input  logic [CNT_W-1:0]    crop_w,
  input  logic [CNT_W-1:0]    crop_h,
  input  logic                fifo_full,
  output logic [PIX_W:0]      fifo_data,
  output logic                fifo_wr_en,
  output logic                frame_done,
  output logic                overflow,
  output logic [CNT_DROP-1:0] drop_cnt,
  output logic [15:0]         frame_cnt
);

  typedef enum logic [1:0] {WAIT_ENABLE, WAIT_BLANK, WAIT_START, CAPTURE} state_t;
  state_t state, state_nx;

  logic             phase, href_q, marker_pending;
  logic [7:0]       hi_byte;
  logic [CNT_W-1:0] col, row;
  logic             gray_q, decim_q;
  logic [CNT_W-1:0] x0_q, y0_q, w_q, h_q;

  logic             enter_cap, in_cap, end_frame, pix_done, emit;
  logic             mark_wr, pix_wr, drop;
  logic [CNT_W:0]   x_end, y_end;
  logic [15:0]      pix_word;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) state <= WAIT_ENABLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = WAIT_ENABLE;
    end else begin
      unique case (state)
        WAIT_ENABLE: state_nx = WAIT_BLANK;
        WAIT_BLANK:  if (cam_vsync)  state_nx = WAIT_START;
        WAIT_START:  if (!cam_vsync) state_nx = CAPTURE;
        CAPTURE:     if (cam_vsync)  state_nx = WAIT_START;
        default:     state_nx = WAIT_ENABLE;
      endcase
    end
  end

  always_comb begin
    enter_cap = (state == WAIT_START) && enable && !cam_vsync;
    in_cap    = (state == CAPTURE) && enable && !cam_vsync;
    end_frame = (state == CAPTURE) && enable && cam_vsync;
    pix_done  = in_cap && href && (gray_q || phase);
    pix_word  = gray_q ? {p_data[7:3], p_data[7:2], p_data[7:3]} : {hi_byte, p_data};
    // Window end computed one bit wider so x0+w never wraps back into range.
    x_end     = {1'b0, x0_q} + {1'b0, w_q};
    y_end     = {1'b0, y0_q} + {1'b0, h_q};
    emit      = pix_done
                && (col >= x0_q) && ({1'b0, col} < x_end)
                && (row >= y0_q) && ({1'b0, row} < y_end)
                && (!decim_q || (!col[0] && !row[0]));
    mark_wr   = in_cap && marker_pending && !fifo_full;
    pix_wr    = emit && !fifo_full && !marker_pending;
    drop      = emit && (fifo_full || marker_pending);
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      phase          <= 1'b0;
      href_q         <= 1'b0;
      marker_pending <= 1'b0;
      hi_byte        <= '0;
      col            <= '0;
      row            <= '0;
      gray_q         <= 1'b0;
      decim_q        <= 1'b0;
      x0_q           <= '0;
      y0_q           <= '0;
      w_q            <= '0;
      h_q            <= '0;
      fifo_data      <= '0;
      fifo_wr_en     <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
      drop_cnt       <= '0;
      frame_cnt      <= '0;
    end else begin
      href_q     <= href;
      fifo_wr_en <= 1'b0;
      frame_done <= 1'b0;
      if (enter_cap) begin
        gray_q         <= gray_mode;
        decim_q        <= decim;
        x0_q           <= crop_x0;
        y0_q           <= crop_y0;
        w_q            <= crop_w;
        h_q            <= crop_h;
        col            <= '0;
        row            <= '0;
        phase          <= 1'b0;
        marker_pending <= 1'b1;
      end else if (in_cap) begin
        if (href) begin
          phase <= ~phase;
          if (!phase) hi_byte <= p_data;
          if (pix_done && (col != '1)) col <= col + 1'b1;
        end else if (href_q) begin
          col   <= '0;
          phase <= 1'b0;
          if (row != '1) row <= row + 1'b1;
        end
        if (mark_wr) begin
          fifo_data      <= {1'b1, {PIX_W{1'b0}}};
          fifo_wr_en     <= 1'b1;
          marker_pending <= 1'b0;
        end else if (pix_wr) begin
          fifo_data  <= {1'b0, PIX_W'(pix_word)};
          fifo_wr_en <= 1'b1;
        end
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
      end
      if (end_frame) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
